// File: rtl/nor_vector_sequencer.sv
// Sweeps the four 2-input vectors onto a NOR gate under test, samples its output once per
// vector and reports pass/fail, a saturating mismatch count and a per-vector fail mask.
module nor_vector_sequencer #(
  parameter int HOLD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       fail_mask,
  output logic [1:0]       vec_idx
);

  localparam int TIMER_W = 8;
  localparam logic [TIMER_W-1:0] SAMPLE_T = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LAST_T   = TIMER_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_r;
  logic [TIMER_W-1:0]   timer_r;
  logic                 sample_s;
  logic                 last_s;
  logic                 expect_s;
  logic                 mismatch_s;
  logic [1:0]           next_vec_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] max_v;
    max_v = {CNT_W{1'b1}};
    return (v == max_v) ? v : v + CNT_W'(1);
  endfunction

  // Sample/advance strobes and the comparison against the ideal NOR of the driven inputs
  always_comb begin
    sample_s   = (state_r == ST_APPLY) && (timer_r == SAMPLE_T);
    last_s     = (timer_r == LAST_T);
    expect_s   = ~(a | b);
    mismatch_s = sample_s && (f != expect_s);
    next_vec_s = vec_idx + 2'd1;
  end

  // Sweep controller: state, drive, timer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TIMER_W{1'b0}};
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= {CNT_W{1'b0}};
      fail_mask <= 4'b0000;
      vec_idx   <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state_r   <= ST_APPLY;
            timer_r   <= {TIMER_W{1'b0}};
            vec_idx   <= 2'd0;
            err_cnt   <= {CNT_W{1'b0}};
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          // Sampling always precedes the last hold edge, so the two never coincide
          if (mismatch_s) begin
            err_cnt            <= sat_inc(err_cnt);
            fail_mask[vec_idx] <= 1'b1;
          end else begin
            err_cnt <= err_cnt;
          end
          if (last_s) begin
            timer_r <= {TIMER_W{1'b0}};
            if (vec_idx == 2'd3) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              a       <= 1'b0;
              b       <= 1'b0;
              pass    <= (err_cnt == {CNT_W{1'b0}});
            end else begin
              vec_idx <= next_vec_s;
              a       <= next_vec_s[1];
              b       <= next_vec_s[0];
            end
          end else begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          a       <= 1'b0;
          b       <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= {TIMER_W{1'b0}};
          a       <= 1'b0;
          b       <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
